// File: rtl/hash_pipe_sched_if.sv
// hash_pipe_sched_if: request, hash-pipe and result bundle for hash_pipe_sched.
//  req_data/req_valid/req_ready : lane windows in; one acceptance per cycle at most
//  hash_a/hash_p                : operand out to and result back from the shared hash pipe
//  res_data/res_valid/res_ready : per-lane result FIFO heads out
//  busy                         : work in flight or results pending
interface hash_pipe_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ*64-1:0] req_data;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [63:0]         hash_a;
    logic [63:0]         hash_p;
    logic [N_REQ*64-1:0] res_data;
    logic [N_REQ-1:0]    res_valid;
    logic [N_REQ-1:0]    res_ready;
    logic                busy;
    modport master (
        output req_data, req_valid, hash_p, res_ready,
        input  req_ready, hash_a, res_data, res_valid, busy
    );
    modport slave (
        input  req_data, req_valid, hash_p, res_ready,
        output req_ready, hash_a, res_data, res_valid, busy
    );
endinterface

// File: rtl/hash_pipe_sched.sv
// hash_pipe_sched: round-robin sharing of one fixed-latency hash pipe between N_REQ lanes.
//  clk, rst : clock and synchronous active-high reset
//  bus      : hash_pipe_sched_if slave; lane i uses req/res data at [i*64+:64]
module hash_pipe_sched #(
    parameter int N_REQ      = 4,
    parameter int HASH_LAT   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    hash_pipe_sched_if.slave bus
);
    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [PW-1:0]     rr_ptr, gnt_id;
    logic [CW-1:0]     credit [N_REQ];
    logic [AW-1:0]     wr_ptr [N_REQ];
    logic [AW-1:0]     rd_ptr [N_REQ];
    logic [AW:0]       count [N_REQ];
    logic [63:0]       mem [N_REQ][FIFO_DEPTH];
    logic [N_REQ-1:0]  elig, grant, pop, wr, full, wen;
    logic              found;
    logic [63:0]       sel_data;
    // Tag stage 0 lines up with hash_a; stage HASH_LAT lines up with the matching hash_p.
    logic [HASH_LAT:0] tag_v;
    logic [PW-1:0]     tag_id [HASH_LAT+1];
    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign elig[g]                  = bus.req_valid[g] && credit[g] != '0;
        assign pop[g]                   = bus.res_valid[g] && bus.res_ready[g];
        assign wr[g]                    = tag_v[HASH_LAT] && tag_id[HASH_LAT] == PW'(g);
        assign full[g]                  = count[g] == (AW+1)'(FIFO_DEPTH);
        assign wen[g]                   = wr[g] && !full[g];
        assign bus.res_valid[g]         = count[g] != '0;
        assign bus.res_data[g*64 +: 64] = mem[g][rd_ptr[g]];
    end
    assign bus.req_ready = grant;
    assign bus.busy      = |tag_v || |bus.res_valid;
    // Search starts at rr_ptr and wraps; lanes without credit are skipped.
    always_comb begin
        found    = 1'b0;
        gnt_id   = '0;
        grant    = '0;
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && elig[(int'(rr_ptr) + k) % N_REQ]) begin
                found  = 1'b1;
                gnt_id = PW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = found && gnt_id == PW'(i);
            sel_data = grant[i] ? bus.req_data[i*64 +: 64] : sel_data;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            bus.hash_a <= '0;
            tag_v      <= '0;
            for (int k = 0; k <= HASH_LAT; k++) tag_id[k] <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                credit[i] <= CW'(FIFO_DEPTH);
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            if (found) rr_ptr <= gnt_id == PW'(N_REQ - 1) ? '0 : gnt_id + 1'b1;
            bus.hash_a <= found ? sel_data : '0;
            tag_v      <= {tag_v[HASH_LAT-1:0], found};
            tag_id[0]  <= gnt_id;
            for (int k = 1; k <= HASH_LAT; k++) tag_id[k] <= tag_id[k-1];
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i] && !pop[i]) credit[i] <= credit[i] - 1'b1;
                else if (!grant[i] && pop[i]) credit[i] <= credit[i] + 1'b1;
                if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (wen[i]) begin
                    mem[i][wr_ptr[i]] <= bus.hash_p;
                    wr_ptr[i]         <= wr_ptr[i] + 1'b1;
                end
                count[i] <= count[i] + (AW+1)'(wen[i]) - (AW+1)'(pop[i]);
`ifndef SYNTHESIS
                if (wr[i] && full[i]) $error("hash_pipe_sched: result FIFO overflow on lane %0d", i);
`endif
            end
        end
    end
endmodule

// File: tb/tb_hash_pipe_sched.sv
// tb_hash_pipe_sched: directed stimulus with a per-lane scoreboard against a p=a*3 pipe model.
module tb_hash_pipe_sched;
    localparam int N   = 4;
    localparam int LAT = 4;
    localparam int DEP = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    int          acc [N];
    logic [63:0] exp_q [N][$];
    logic [63:0] p_reg [LAT];
    hash_pipe_sched_if #(.N_REQ(N)) bus ();
    hash_pipe_sched #(.N_REQ(N), .HASH_LAT(LAT), .FIFO_DEPTH(DEP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        p_reg[0] <= bus.hash_a * 64'd3;
        for (int k = 1; k < LAT; k++) p_reg[k] <= p_reg[k-1];
    end
    assign bus.hash_p = p_reg[LAT-1];
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    acc[i]++;
                    exp_q[i].push_back(bus.req_data[i*64 +: 64] * 64'd3);
                end
                if (bus.res_valid[i] && bus.res_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_extra lane%0d got=%h exp=none", i, bus.res_data[i*64 +: 64]);
                    end else begin
                        chk($sformatf("sb_lane%0d", i), bus.res_data[i*64 +: 64], exp_q[i].pop_front());
                    end
                end
            end
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask
    task automatic clr_acc();
        for (int i = 0; i < N; i++) acc[i] = 0;
    endtask
    task automatic set_data(input int k);
        for (int i = 0; i < N; i++) bus.req_data[i*64 +: 64] = {8'(i + 1), 24'h5A5A5A, 32'(k)};
    endtask
    task automatic drain();
        int n;
        n = 0;
        bus.req_valid = '0;
        bus.res_ready = '1;
        do begin
            cyc();
            mid();
            n++;
        end while (bus.busy && n < 40);
        chk("drain_busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < N; i++) chk($sformatf("drain_q%0d", i), 64'(exp_q[i].size()), 64'd0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        clr_acc();
        bus.req_valid = '0;
        bus.res_ready = '0;
        bus.req_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mid();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_hash_a", bus.hash_a, 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        // 1: single request on lane 2
        cyc();
        bus.req_data[128 +: 64] = 64'h0123456789ABCDEF;
        bus.req_valid = 4'b0100;
        mid();
        chk("t1_grant", 64'(bus.req_ready), 64'h4);
        cyc();
        bus.req_valid = '0;
        mid();
        chk("t1_hash_a", bus.hash_a, 64'h0123456789ABCDEF);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        repeat (4) begin
            cyc();
            mid();
            chk("t1_early", 64'(bus.res_valid), 64'd0);
        end
        cyc();
        mid();
        chk("t1_res_valid", 64'(bus.res_valid), 64'h4);
        chk("t1_res_data", bus.res_data[128 +: 64], 64'h0369D0369D0369CD);
        cyc();
        bus.res_ready = '1;
        mid();
        cyc();
        mid();
        chk("t1_popped", 64'(bus.res_valid), 64'd0);
        chk("t1_idle", 64'(bus.busy), 64'd0);
        cyc();
        clr_acc();
        bus.res_ready = 4'b1011;
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            set_data(k);
            mid();
            cyc();
        end
        chk("t1_credit", 64'(acc[2]), 64'd4);
        drain();
        // 6: idle, pointer left at lane 3
        for (int k = 0; k < 10; k++) begin
            cyc();
            mid();
            chk("t6_hash_a", bus.hash_a, 64'd0);
            chk("t6_req_ready", 64'(bus.req_ready), 64'd0);
            chk("t6_busy", 64'(bus.busy), 64'd0);
        end
        // 2: all lanes continuously
        cyc();
        clr_acc();
        bus.res_ready = '1;
        bus.req_valid = '1;
        for (int k = 0; k < 16; k++) begin
            set_data(20 + k);
            mid();
            chk($sformatf("t2_grant%0d", k), 64'(bus.req_ready), 64'(4'b0001 << ((3 + k) % 4)));
            cyc();
        end
        for (int i = 0; i < N; i++) chk($sformatf("t2_share%0d", i), 64'(acc[i]), 64'd4);
        drain();
        // 3: lane 1 results held back until its credits run out
        cyc();
        clr_acc();
        bus.res_ready = 4'b1101;
        bus.req_valid = 4'b1011;
        for (int k = 0; k < 20; k++) begin
            set_data(40 + k);
            mid();
            cyc();
        end
        mid();
        chk("t3_acc1", 64'(acc[1]), 64'd4);
        chk("t3_blocked", 64'(bus.req_ready[1]), 64'd0);
        chk("t3_others", 64'(|bus.req_ready), 64'd1);
        cyc();
        clr_acc();
        bus.res_ready = '1;
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            set_data(70 + k);
            mid();
            cyc();
        end
        chk("t3_resume", 64'(acc[1] >= 4), 64'd1);
        drain();
        // 4: pop and grant together on lane 0 at credit 1
        cyc();
        bus.res_ready = 4'b1110;
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            set_data(200 + k);
            mid();
            chk("t4_fill", 64'(bus.req_ready), 64'h1);
            cyc();
        end
        bus.req_valid = '0;
        repeat (8) begin
            mid();
            cyc();
        end
        mid();
        chk("t4_held", 64'(bus.res_valid), 64'h1);
        cyc();
        bus.req_valid = 4'b0001;
        bus.res_ready = '1;
        set_data(210);
        mid();
        chk("t4_same_cycle", 64'(bus.req_ready), 64'h1);
        cyc();
        bus.res_ready = 4'b1110;
        set_data(211);
        mid();
        chk("t4_next", 64'(bus.req_ready), 64'h1);
        cyc();
        mid();
        chk("t4_empty", 64'(bus.req_ready), 64'd0);
        drain();
        // 5: reset with FIFO entries and tags in flight
        cyc();
        bus.res_ready = 4'b1100;
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            set_data(300 + k);
            mid();
            cyc();
        end
        bus.req_valid = '0;
        repeat (8) begin
            mid();
            cyc();
        end
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            set_data(310 + k);
            mid();
            cyc();
        end
        bus.req_valid = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        mid();
        chk("t5_res_valid", 64'(bus.res_valid), 64'd0);
        chk("t5_busy", 64'(bus.busy), 64'd0);
        bus.res_ready = '1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            mid();
            chk("t5_quiet", 64'(bus.res_valid), 64'd0);
        end
        cyc();
        clr_acc();
        bus.res_ready = 4'b1101;
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            set_data(400 + k);
            mid();
            cyc();
        end
        chk("t5_credit", 64'(acc[1]), 64'd4);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
